// File: rtl/pipe_ctrl_stage.sv
// rtl/pipe_ctrl_stage.sv - parametrised control/data pipeline register with stall, flush and event counters
//
// Purpose
//   Carries the control and data bundle between two pipeline stages through
//   DEPTH register slots in series. Each slot holds a valid bit, control bits
//   and a data payload. Stall holds the whole chain; flush turns every slot
//   into a bubble. Write enables leave through ctrl_gated_o, which is forced
//   to zero for an invalid slot so a killed instruction can never commit.
//   Two saturating counters record stall and flush cycles for debug.
//
// Ports
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous active-high reset
//   stall_i      in   1       hold every slot this cycle
//   flush_i      in   1       invalidate every slot, drop the input
//   valid_i      in   1       input slot carries a real instruction
//   ctrl_i       in   CTRL_W  control bits from upstream
//   data_i       in   DATA_W  payload from upstream
//   clr_cnt_i    in   1       synchronous clear of both counters
//   valid_o      out  1       valid bit of the last slot
//   ctrl_o       out  CTRL_W  raw control bits of the last slot
//   ctrl_gated_o out  CTRL_W  ctrl_o masked by valid_o
//   data_o       out  DATA_W  payload of the last slot
//   stall_cnt_o  out  CNT_W   stall-only cycles, saturating
//   flush_cnt_o  out  CNT_W   flush cycles, saturating

module pipe_ctrl_stage #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              clr_cnt_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [CTRL_W-1:0] ctrl_gated_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : gDepthCheck
            $error("pipe_ctrl_stage: DEPTH must be in 1..4");
        end
    endgenerate

    logic              validQ [DEPTH];
    logic [CTRL_W-1:0] ctrlQ  [DEPTH];
    logic [DATA_W-1:0] dataQ  [DEPTH];

    logic [CNT_W-1:0]  stallCnt;
    logic [CNT_W-1:0]  flushCnt;

    // Slot chain. Flush clears valid and ctrl but leaves data alone: payload
    // of a bubble is don't-care, and not touching it saves enable fan-out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                validQ[k] <= 1'b0;
                ctrlQ[k]  <= '0;
                dataQ[k]  <= '0;
            end
        end else if (flush_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                validQ[k] <= 1'b0;
                ctrlQ[k]  <= '0;
            end
        end else if (!stall_i) begin
            validQ[0] <= valid_i;
            // An invalid input never carries live control into the pipe.
            ctrlQ[0]  <= valid_i ? ctrl_i : '0;
            dataQ[0]  <= data_i;
            for (int k = 1; k < DEPTH; k++) begin
                validQ[k] <= validQ[k-1];
                ctrlQ[k]  <= ctrlQ[k-1];
                dataQ[k]  <= dataQ[k-1];
            end
        end
    end

    // Event counters: clear wins over increment, and both stick at all-ones.
    // A stall during a flush counts as a flush only, since flush wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else if (clr_cnt_i) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stall_i && !flush_i && !(&stallCnt)) begin
                stallCnt <= stallCnt + 1'b1;
            end
            if (flush_i && !(&flushCnt)) begin
                flushCnt <= flushCnt + 1'b1;
            end
        end
    end

    assign valid_o      = validQ[DEPTH-1];
    assign ctrl_o       = ctrlQ[DEPTH-1];
    assign data_o       = dataQ[DEPTH-1];
    assign ctrl_gated_o = ctrlQ[DEPTH-1] & {CTRL_W{validQ[DEPTH-1]}};
    assign stall_cnt_o  = stallCnt;
    assign flush_cnt_o  = flushCnt;

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// tb/tb_pipe_ctrl_stage.sv - directed self-checking bench for pipe_ctrl_stage (DEPTH=2, CNT_W=4)

module tb_pipe_ctrl_stage;

    localparam int CTRL_W = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              stallIn;
    logic              flushIn;
    logic              validIn;
    logic [CTRL_W-1:0] ctrlIn;
    logic [DATA_W-1:0] dataIn;
    logic              clrCnt;
    logic              validOut;
    logic [CTRL_W-1:0] ctrlOut;
    logic [CTRL_W-1:0] ctrlGated;
    logic [DATA_W-1:0] dataOut;
    logic [CNT_W-1:0]  stallCnt;
    logic [CNT_W-1:0]  flushCnt;

    int errCount = 0;
    int chkCount = 0;

    always #5 clk = ~clk;

    pipe_ctrl_stage #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stallIn),
        .flush_i     (flushIn),
        .valid_i     (validIn),
        .ctrl_i      (ctrlIn),
        .data_i      (dataIn),
        .clr_cnt_i   (clrCnt),
        .valid_o     (validOut),
        .ctrl_o      (ctrlOut),
        .ctrl_gated_o(ctrlGated),
        .data_o      (dataOut),
        .stall_cnt_o (stallCnt),
        .flush_cnt_o (flushCnt)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        validIn = v;
        ctrlIn  = c;
        dataIn  = d;
    endtask

    task automatic checkOut(input string tag, input logic v, input logic [CTRL_W-1:0] c,
                            input logic [CTRL_W-1:0] g, input logic [DATA_W-1:0] d);
        checkVal({tag, ".valid"}, {31'b0, validOut}, {31'b0, v});
        checkVal({tag, ".ctrl"},  {28'b0, ctrlOut},  {28'b0, c});
        checkVal({tag, ".gated"}, {28'b0, ctrlGated}, {28'b0, g});
        checkVal({tag, ".data"},  dataOut, d);
    endtask

    task automatic checkCnt(input string tag, input int s, input int f);
        checkVal({tag, ".stallCnt"}, {28'b0, stallCnt}, s);
        checkVal({tag, ".flushCnt"}, {28'b0, flushCnt}, f);
    endtask

    initial begin
        rst     = 1'b1;
        stallIn = 1'b0;
        flushIn = 1'b0;
        clrCnt  = 1'b0;
        drive(1'b0, 4'b0000, 32'h0);
        #1;
        checkOut("reset", 1'b0, 4'b0000, 4'b0000, 32'h0);
        checkCnt("reset", 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // pass-through, two-slot latency
        drive(1'b1, 4'b1011, 32'hDEAD_BEEF);
        tick();
        checkVal("pass.notYet", {31'b0, validOut}, 32'd0);
        drive(1'b1, 4'b0110, 32'hCAFE_F00D);
        tick();
        checkOut("pass", 1'b1, 4'b1011, 4'b1011, 32'hDEAD_BEEF);

        // stall three cycles; upstream holds its next item
        stallIn = 1'b1;
        drive(1'b1, 4'b0001, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOut($sformatf("stall%0d", i), 1'b1, 4'b1011, 4'b1011, 32'hDEAD_BEEF);
        end
        checkCnt("stall", 3, 0);
        stallIn = 1'b0;
        tick();
        checkOut("resume1", 1'b1, 4'b0110, 4'b0110, 32'hCAFE_F00D);
        drive(1'b0, 4'b1111, 32'hAAAA_5555);
        tick();
        checkOut("resume2", 1'b1, 4'b0001, 4'b0001, 32'h1234_5678);

        // invalid input carries no control
        drive(1'b1, 4'b1100, 32'hBBBB_0000);
        tick();
        checkOut("invalid", 1'b0, 4'b0000, 4'b0000, 32'hAAAA_5555);

        // flush together with stall and a valid input
        flushIn = 1'b1;
        stallIn = 1'b1;
        drive(1'b1, 4'b1011, 32'h7777_7777);
        tick();
        checkOut("flush", 1'b0, 4'b0000, 4'b0000, 32'hAAAA_5555);
        checkCnt("flush", 3, 1);
        flushIn = 1'b0;
        stallIn = 1'b0;
        drive(1'b0, 4'b0000, 32'h0);
        tick();
        checkOut("flush.adv1", 1'b0, 4'b0000, 4'b0000, 32'hBBBB_0000);
        tick();
        checkOut("flush.adv2", 1'b0, 4'b0000, 4'b0000, 32'h0);

        // saturation and clear
        stallIn = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checkCnt("sat", 15, 1);
        clrCnt = 1'b1;
        tick();
        checkCnt("clr", 0, 0);
        clrCnt = 1'b0;
        tick();
        checkCnt("afterClr", 1, 0);

        // mid-stream asynchronous reset
        stallIn = 1'b0;
        drive(1'b1, 4'b1111, 32'hFFFF_0000);
        tick();
        tick();
        checkOut("preRst", 1'b1, 4'b1111, 4'b1111, 32'hFFFF_0000);
        #2;
        rst = 1'b1;
        #1;
        checkOut("midRst", 1'b0, 4'b0000, 4'b0000, 32'h0);
        checkCnt("midRst", 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 4'b0000, 32'h0);
        tick();
        checkOut("postRst", 1'b0, 4'b0000, 4'b0000, 32'h0);

        $display("Result: errors=%0d of %0d checks", errCount, chkCount);
        $finish;
    end

endmodule
